// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: 3-stage pipelined floating-point add/sub with RNE rounding, specials, flags and valid/ready flow control
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int AW = MAN_W + 4;
  localparam int SW = MAN_W + 5;
  localparam logic [EXP_W-1:0] E_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, E_ONES, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W:0] SAT = (EXP_W+1)'(MAN_W + 3);
  logic adv;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  logic sa, sb, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap, spec, spec_inv;
  logic [EXP_W-1:0] ea, eb, ex, ey;
  logic [MAN_W-1:0] ma, mb;
  logic [EXP_W:0] d;
  logic [AW-1:0] xf, yf, ysh, ymask, yal;
  logic [W-1:0] spec_res;
  assign sa = a[W-1];
  assign sb = b[W-1] ^ op_sub;
  assign ea = a[W-2:MAN_W];
  assign eb = b[W-2:MAN_W];
  assign ma = a[MAN_W-1:0];
  assign mb = b[MAN_W-1:0];
  assign a_nan = ea == E_ONES && ma != '0;
  assign b_nan = eb == E_ONES && mb != '0;
  assign a_inf = ea == E_ONES && ma == '0;
  assign b_inf = eb == E_ONES && mb == '0;
  assign a_zero = ea == '0;
  assign b_zero = eb == '0;
  assign swap = b[W-2:0] > a[W-2:0];
  assign ex = swap ? eb : ea;
  assign ey = swap ? ea : eb;
  assign xf = {1'b1, swap ? mb : ma, 3'b000};
  assign yf = {1'b1, swap ? ma : mb, 3'b000};
  assign d = {1'b0, ex} - {1'b0, ey};
  assign ysh = yf >> d;
  assign ymask = ~({AW{1'b1}} << d);
  // bits shifted past the low end collapse into the sticky position
  assign yal = d >= SAT ? AW'(1) : {ysh[AW-1:1], ysh[0] | |(yf & ymask)};
  assign spec_inv = !(a_nan || b_nan) && a_inf && b_inf && sa != sb;
  assign spec = a_nan || b_nan || a_inf || b_inf || a_zero || b_zero;
  assign spec_res = (a_nan || b_nan || spec_inv) ? QNAN :
                    a_inf ? {sa, E_ONES, {MAN_W{1'b0}}} :
                    b_inf ? {sb, E_ONES, {MAN_W{1'b0}}} :
                    (a_zero && b_zero) ? {sa && sb, {(W-1){1'b0}}} :
                    a_zero ? {sb, b[W-2:0]} : a;
  logic s1_v, s1_spec, s1_inv, s1_sign, s1_sub;
  logic [W-1:0] s1_res;
  logic [EXP_W-1:0] s1_exp;
  logic [AW-1:0] s1_x, s1_y;
  always_ff @(posedge clk) begin
    if (reset) s1_v <= 1'b0;
    else if (adv) s1_v <= in_valid;
    if (adv) begin
      s1_spec <= spec;
      s1_inv <= spec_inv;
      s1_res <= spec_res;
      s1_sign <= swap ? sb : sa;
      s1_sub <= sa != sb;
      s1_exp <= ex;
      s1_x <= xf;
      s1_y <= yal;
    end
  end
  logic s2_v, s2_spec, s2_inv, s2_sign;
  logic [W-1:0] s2_res;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0] s2_sum;
  always_ff @(posedge clk) begin
    if (reset) s2_v <= 1'b0;
    else if (adv) s2_v <= s1_v;
    if (adv) begin
      s2_spec <= s1_spec;
      s2_inv <= s1_inv;
      s2_res <= s1_res;
      s2_sign <= s1_sign;
      s2_exp <= s1_exp;
      s2_sum <= s1_sub ? {1'b0, s1_x} - {1'b0, s1_y} : {1'b0, s1_x} + {1'b0, s1_y};
    end
  end
  int lz, e_f;
  logic [SW-1:0] nrm;
  logic [MAN_W:0] mr;
  logic g, st, zr, unf, ovf;
  logic [W-1:0] r3;
  logic [3:0] f3;
  // normalise so the leading one lands in the top bit; exponent is ex+1-lz
  always_comb begin
    lz = 0;
    for (int i = 0; i < SW; i++) if (s2_sum[i]) lz = SW - 1 - i;
    nrm = s2_sum << lz;
    g = nrm[3];
    st = |nrm[2:0];
    zr = !nrm[SW-1];
    mr = {1'b0, nrm[SW-2:4]} + (MAN_W+1)'(g && (st || nrm[4]));
    e_f = int'(s2_exp) + 1 - lz + int'(mr[MAN_W]);
    unf = e_f <= 0;
    ovf = e_f >= (1 << EXP_W) - 1;
    r3 = s2_spec ? s2_res :
         zr ? '0 :
         unf ? {s2_sign, {(W-1){1'b0}}} :
         ovf ? {s2_sign, E_ONES, {MAN_W{1'b0}}} :
         {s2_sign, e_f[EXP_W-1:0], mr[MAN_W-1:0]};
    f3 = s2_spec ? {s2_inv, 3'b000} :
         zr ? 4'b0000 :
         unf ? 4'b0011 :
         ovf ? 4'b0101 :
         {3'b000, g || st};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result <= '0;
      flags <= '0;
    end else if (adv) begin
      out_valid <= s2_v;
      result <= r3;
      flags <= f3;
    end
  end
endmodule
